// File: rtl/ringosc_freq_ctrl.sv
// Ring oscillator frequency measurement sequencer: enable ring, settle, count
// synchronised ring toggle edges over a gate window of clk cycles, report.
module ringosc_freq_ctrl #(
  parameter int GATE_W      = 20,
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              ro_en,
  input  logic              ro_tog,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  // Handshake: start is a level sampled only while idle; done is a one-cycle
  // pulse after which count/overflow stay valid until the next accepted start.

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [GATE_W-1:0]   gate_q;
  logic [GATE_W-1:0]   gate_cnt;
  logic [SW-1:0]       settle_cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                hist;
  logic                tog_edge;
  logic                ro_en_nx, busy_nx, done_nx;

  assign tog_edge  = sync[SYNC_STAGES-1] ^ hist;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    ro_en_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = S_SETTLE;
      S_SETTLE:  if (settle_cnt == '0)
                   state_nx = (gate_q == '0) ? S_DONE : S_MEASURE;
      S_MEASURE: if (gate_cnt == '0) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    // Outputs are registered from the next state so ro_en never glitches.
    ro_en_nx = (state_nx == S_SETTLE) || (state_nx == S_MEASURE);
    busy_nx  = ro_en_nx;
    done_nx  = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
      gate_q     <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      sync       <= '0;
      hist       <= 1'b0;
    end else begin
      state <= state_nx;
      ro_en <= ro_en_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      // The synchroniser runs in every state so the history is current at gate open.
      sync  <= {sync[SYNC_STAGES-2:0], ro_tog};
      hist  <= sync[SYNC_STAGES-1];
      case (state)
        S_IDLE: if (start) begin
          gate_q     <= gate_cycles;
          count      <= '0;
          overflow   <= 1'b0;
          settle_cnt <= SW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            if (gate_q != '0) gate_cnt <= gate_q - GATE_W'(1);
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_MEASURE: begin
          if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_W'(1);
          if (tog_edge) begin
            if (count == {CNT_W{1'b1}}) overflow <= 1'b1;
            else count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ringosc_freq_ctrl.sv
// Bench for ringosc_freq_ctrl: two instances (16-bit and 4-bit counters) checked
// every cycle against a window-arithmetic model of the measurement schedule.
module tb_ringosc_freq_ctrl;
  localparam int GATE_W = 20;
  localparam int SETTLE = 16;

  logic clk = 1'b0;
  logic rst, start, ro_tog;
  logic [GATE_W-1:0] gate_cycles;
  logic ro_en_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic [1:0] st_a;
  logic ro_en_b, busy_b, done_b, ovf_b;
  logic [3:0] count_b;
  logic [1:0] st_b;

  ringosc_freq_ctrl #(.GATE_W(GATE_W), .CNT_W(16), .SETTLE(SETTLE), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .ro_en(ro_en_a),
    .ro_tog(ro_tog), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a),
    .dbg_state(st_a));

  ringosc_freq_ctrl #(.GATE_W(GATE_W), .CNT_W(4), .SETTLE(SETTLE), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .ro_en(ro_en_b),
    .ro_tog(ro_tog), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b),
    .dbg_state(st_b));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int p = 0;
  bit chk_en = 0;
  bit active = 0;
  int e = 0;
  int g = 0;
  int tog_q[$];
  int done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at period %0d: got %0d expected %0d", name, p, act, exp);
  endtask

  // A toggle driven in period n shows as an edge pulse in period n+2; it counts
  // when that period lies in the gate window [e+SETTLE, e+SETTLE+g-1].
  function automatic int edges_upto(input int q);
    int lo, hi, n;
    lo = e + SETTLE;
    hi = e + SETTLE + g - 1;
    if (q - 1 < hi) hi = q - 1;
    n = 0;
    foreach (tog_q[i]) if (tog_q[i] + 2 >= lo && tog_q[i] + 2 <= hi) n++;
    return n;
  endfunction

  // Model: a start sampled at edge p is accepted iff period p-1 was idle.
  always @(posedge clk) begin
    p = p + 1;
    if (rst) active = 0;
    else if (start && !(active && (p - 1) <= e + SETTLE + g)) begin
      active = 1;
      e = p;
      g = int'(gate_cycles);
      tog_q.delete();
    end
  end

  always @(negedge clk) begin : compare
    bit exp_busy, exp_done;
    int n;
    if (chk_en) begin
      exp_busy = active && p >= e && p < e + SETTLE + g;
      exp_done = active && p == e + SETTLE + g;
      n = active ? edges_upto(p) : 0;
      check("busy_a",  32'(busy_a),  32'(exp_busy));
      check("ro_en_a", 32'(ro_en_a), 32'(exp_busy));
      check("done_a",  32'(done_a),  32'(exp_done));
      check("count_a", 32'(count_a), (n > 65535) ? 32'd65535 : 32'(n));
      check("ovf_a",   32'(ovf_a),   32'(n > 65535));
      check("busy_b",  32'(busy_b),  32'(exp_busy));
      check("done_b",  32'(done_b),  32'(exp_done));
      check("count_b", 32'(count_b), (n > 15) ? 32'd15 : 32'(n));
      check("ovf_b",   32'(ovf_b),   32'(n > 15));
      if (done_a || done_b) done_q.push_back(p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_toggle();
    ro_tog = ~ro_tog;
    tog_q.push_back(p);
  endtask

  // Starts one measurement from idle; toggles at offsets first+i*spacing from
  // the first SETTLE period, or randomly (with start/gate noise) when rnd=1.
  task automatic run(input int gate, input int first, input int spacing, input int ntog,
                     input bit rnd, output int ep, output int dp);
    bit seen;
    gate_cycles = GATE_W'(gate);
    start = 1'b1;
    tick();
    ep = p;
    start = 1'b0;
    seen = 0;
    dp = -1;
    for (int k = 0; k < SETTLE + gate + 20 && !seen; k++) begin
      if (!rnd) begin
        if (ntog > 0 && k >= first && (k - first) % spacing == 0 && (k - first) / spacing < ntog)
          do_toggle();
      end else begin
        if ($urandom_range(0, 2) == 0) do_toggle();
        gate_cycles = GATE_W'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      if (done_a) begin
        seen = 1;
        dp = p;
      end else begin
        tick();
      end
    end
    tick();
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ep, dp, n0;
    rst = 1'b1;
    start = 1'b0;
    ro_tog = 1'b0;
    gate_cycles = '0;
    tick();
    chk_en = 1;
    tick();
    check("reset_state", 32'(st_a), 32'd0);
    check("reset_count", 32'(count_a), 32'd0);
    check("reset_ro_en", 32'(ro_en_a), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal: 10 toggles every 5 cycles inside a 100-cycle gate.
    run(100, SETTLE + 4, 5, 10, 0, ep, dp);
    check("t1_done_at", 32'(dp - ep), 32'(SETTLE + 100));
    check("t1_count", 32'(count_a), 32'd10);
    check("t1_ovf", 32'(ovf_a), 32'd0);

    // Toggles only during settle must not count.
    run(50, 1, 2, 6, 0, ep, dp);
    check("t2_count", 32'(count_a), 32'd0);

    // Saturation of the 4-bit instance, then a clean run clears overflow.
    run(200, SETTLE + 2, 4, 20, 0, ep, dp);
    check("t3_count_b", 32'(count_b), 32'd15);
    check("t3_ovf_b", 32'(ovf_b), 32'd1);
    check("t3_count_a", 32'(count_a), 32'd20);
    run(60, SETTLE + 3, 7, 3, 0, ep, dp);
    check("t3_clean_count_b", 32'(count_b), 32'd3);
    check("t3_clean_ovf_b", 32'(ovf_b), 32'd0);

    // Zero gate: done right after settle, nothing counted.
    run(0, 2, 3, 4, 0, ep, dp);
    check("t4_done_at", 32'(dp - ep), 32'(SETTLE));
    check("t4_count", 32'(count_a), 32'd0);

    // start held high: back-to-back measurements with one idle cycle between.
    n0 = done_q.size();
    gate_cycles = GATE_W'(30);
    start = 1'b1;
    repeat (3 * (SETTLE + 32) + 5) tick();
    start = 1'b0;
    repeat (SETTLE + 40) tick();
    check("t5_done_count", 32'(done_q.size() - n0 >= 3), 32'd1);
    if (done_q.size() - n0 >= 2)
      check("t5_done_spacing", 32'(done_q[n0 + 1] - done_q[n0]), 32'(SETTLE + 32));

    // Reset mid-measure: immediate idle, no done, then a clean measurement.
    gate_cycles = GATE_W'(100);
    start = 1'b1;
    tick();
    ep = p;
    start = 1'b0;
    while (p < ep + 39) begin
      if ((p - ep) % 3 == 0) do_toggle();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy_a), 32'd0);
    check("t6_ro_en", 32'(ro_en_a), 32'd0);
    check("t6_count", 32'(count_a), 32'd0);
    n0 = done_q.size();
    repeat (150) tick();
    check("t6_no_done", 32'(done_q.size()), 32'(n0));
    run(40, SETTLE + 1, 3, 5, 0, ep, dp);
    check("t6_fresh_count", 32'(count_a), 32'd5);

    // Randomised measurements with start and gate_cycles noise while busy.
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(0, 300)), 0, 1, 0, 1, ep, dp);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
